// File: rtl/decoder_scan_pkg.sv
// Shared mode encodings and one-hot decode helper for the decoder_scan block.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_HOLD    = 2'b01,
    MODE_SCAN_UP = 2'b10,
    MODE_SCAN_DN = 2'b11
  } mode_e;

  // Widest select supported; callers truncate the result to their own 2**SEL_W.
  localparam int unsigned SEL_W_MAX = 8;
  localparam int unsigned OH_W_MAX  = 2 ** SEL_W_MAX;

  function automatic logic [OH_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/scan_div.sv
// Scan prescaler: counts enabled cycles 0..DIV_MAX-1 and flags the wrap cycle.
module scan_div #(
  parameter int unsigned DIV_MAX = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic          at_max;

  assign at_max = (cnt_q == CW'(DIV_MAX - 1));
  assign tick   = en && !clr && at_max;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (en) begin
      if (clr || at_max) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct select, hold, and prescaled up/down scanning.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DIV_MAX = 4,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  step
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  mode_e              mode_s;
  logic               is_scan;
  logic               tick;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_up;
  logic [SEL_W-1:0]   idx_dn;
  logic [OUT_W-1:0]   oh_q;
  logic               valid_q;
  logic               step_q;

  assign mode_s  = mode_e'(mode);
  assign is_scan = (mode_s == MODE_SCAN_UP) || (mode_s == MODE_SCAN_DN);
  assign idx_up  = idx_q + SEL_W'(1);
  assign idx_dn  = idx_q - SEL_W'(1);

  // Any enabled non-scan cycle zeroes the prescaler, so scan entry restarts the count.
  scan_div #(
    .DIV_MAX (DIV_MAX)
  ) u_scan_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .clr     (!is_scan),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q   <= '0;
      oh_q    <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (en) begin
        case (mode_s)
          MODE_DIRECT: begin
            idx_q   <= sel;
            oh_q    <= OUT_W'(onehot(SEL_W_MAX'(sel)));
            valid_q <= 1'b1;
          end
          MODE_HOLD: ;
          MODE_SCAN_UP: begin
            if (tick) begin
              idx_q   <= idx_up;
              oh_q    <= OUT_W'(onehot(SEL_W_MAX'(idx_up)));
              valid_q <= 1'b1;
              step_q  <= 1'b1;
            end
          end
          MODE_SCAN_DN: begin
            if (tick) begin
              idx_q   <= idx_dn;
              oh_q    <= OUT_W'(onehot(SEL_W_MAX'(idx_dn)));
              valid_q <= 1'b1;
              step_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  if (ACT_LOW) begin : g_act_low
    assign out = ~oh_q;
  end else begin : g_act_high
    assign out = oh_q;
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign step  = step_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: scoreboard queues hold expected outputs per cycle.
module tb_decoder_scan;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic [2:0] idx;
    logic       valid;
    logic       step;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       en      = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic [2:0] sel     = 3'd0;

  logic [7:0] out, out_lo, out_d1;
  logic [2:0] idx, idx_lo, idx_d1;
  logic       valid, valid_lo, valid_d1;
  logic       step, step_lo, step_d1;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q2[$];

  always #5 sys_clk = ~sys_clk;

  decoder_scan #(.SEL_W(3), .DIV_MAX(4), .ACT_LOW(1'b0)) u_dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode), .sel (sel),
    .out (out), .idx (idx), .valid (valid), .step (step)
  );

  decoder_scan #(.SEL_W(3), .DIV_MAX(4), .ACT_LOW(1'b1)) u_dut_lo (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode), .sel (sel),
    .out (out_lo), .idx (idx_lo), .valid (valid_lo), .step (step_lo)
  );

  decoder_scan #(.SEL_W(3), .DIV_MAX(1), .ACT_LOW(1'b0)) u_dut_d1 (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode), .sel (sel),
    .out (out_d1), .idx (idx_d1), .valid (valid_d1), .step (step_d1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: outputs sampled on the falling edge, one scoreboard entry per queue.
  task automatic cyc();
    exp_t       e;
    logic [7:0] inv;
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (q0.size() != 0) begin
      e   = q0.pop_front();
      inv = ~e.out;
      chk({e.tag, ".out"},      {24'h0, out},      {24'h0, e.out});
      chk({e.tag, ".idx"},      {29'h0, idx},      {29'h0, e.idx});
      chk({e.tag, ".valid"},    {31'h0, valid},    {31'h0, e.valid});
      chk({e.tag, ".step"},     {31'h0, step},     {31'h0, e.step});
      chk({e.tag, ".out_lo"},   {24'h0, out_lo},   {24'h0, inv});
      chk({e.tag, ".idx_lo"},   {29'h0, idx_lo},   {29'h0, e.idx});
      chk({e.tag, ".valid_lo"}, {31'h0, valid_lo}, {31'h0, e.valid});
      chk({e.tag, ".step_lo"},  {31'h0, step_lo},  {31'h0, e.step});
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk({e.tag, ".d1_out"},   {24'h0, out_d1},   {24'h0, e.out});
      chk({e.tag, ".d1_idx"},   {29'h0, idx_d1},   {29'h0, e.idx});
      chk({e.tag, ".d1_valid"}, {31'h0, valid_d1}, {31'h0, e.valid});
      chk({e.tag, ".d1_step"},  {31'h0, step_d1},  {31'h0, e.step});
    end
  endtask

  task automatic go(input string tag, input logic [7:0] o, input logic [2:0] i,
                    input logic v, input logic s);
    exp_t e;
    e = '{tag: tag, out: o, idx: i, valid: v, step: s};
    q0.push_back(e);
    cyc();
  endtask

  task automatic go_n(input int n, input string tag, input logic [7:0] o,
                      input logic [2:0] i, input logic v, input logic s);
    for (int k = 0; k < n; k++) go(tag, o, i, v, s);
  endtask

  task automatic go2(input string tag, input logic [7:0] o, input logic [2:0] i,
                     input logic v, input logic s);
    exp_t e;
    e = '{tag: tag, out: o, idx: i, valid: v, step: s};
    q2.push_back(e);
    cyc();
  endtask

  initial begin
    logic [2:0] exp_i;

    // Reset held for two cycles, then released with en low.
    cyc();
    go("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    go("rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // DIRECT decode, one-cycle latency.
    en = 1'b1; mode = 2'b00; sel = 3'd5;
    go("direct5", 8'h20, 3'd5, 1'b1, 1'b0);
    sel = 3'd0;
    go("direct0", 8'h01, 3'd0, 1'b1, 1'b0);
    sel = 3'd2;
    go("direct2", 8'h04, 3'd2, 1'b1, 1'b0);
    sel = 3'd6;
    go("direct6", 8'h40, 3'd6, 1'b1, 1'b0);

    // SCAN_UP from idx 6: advance every 4 enabled cycles, wrap 7 -> 0.
    mode = 2'b10;
    go_n(3, "up_wait1", 8'h40, 3'd6, 1'b1, 1'b0);
    go("up_adv7", 8'h80, 3'd7, 1'b1, 1'b1);
    go_n(3, "up_wait2", 8'h80, 3'd7, 1'b1, 1'b0);
    go("up_wrap0", 8'h01, 3'd0, 1'b1, 1'b1);
    go("up_after", 8'h01, 3'd0, 1'b1, 1'b0);

    // SCAN_DN with a freeze in the middle of the count.
    mode = 2'b01;
    go("hold_clr", 8'h01, 3'd0, 1'b1, 1'b0);
    mode = 2'b11;
    go_n(2, "dn_run1", 8'h01, 3'd0, 1'b1, 1'b0);
    en = 1'b0;
    go_n(5, "dn_frz", 8'h01, 3'd0, 1'b1, 1'b0);
    en = 1'b1;
    go("dn_run2", 8'h01, 3'd0, 1'b1, 1'b0);
    go("dn_adv7", 8'h80, 3'd7, 1'b1, 1'b1);
    go("dn_after", 8'h80, 3'd7, 1'b1, 1'b0);

    // HOLD mid-scan, then a reset during SCAN_UP.
    mode = 2'b00; sel = 3'd3;
    go("direct3", 8'h08, 3'd3, 1'b1, 1'b0);
    mode = 2'b10;
    go_n(2, "up3_run", 8'h08, 3'd3, 1'b1, 1'b0);
    mode = 2'b01;
    go_n(10, "hold10", 8'h08, 3'd3, 1'b1, 1'b0);
    mode = 2'b10;
    go_n(2, "up3_rerun", 8'h08, 3'd3, 1'b1, 1'b0);
    sys_rst = 1'b1;
    go("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    go_n(3, "rel_wait", 8'h00, 3'd0, 1'b0, 1'b0);
    go("rel_adv1", 8'h02, 3'd1, 1'b1, 1'b1);

    // Direction flip mid-count keeps the prescaler phase.
    go_n(2, "flip_up", 8'h02, 3'd1, 1'b1, 1'b0);
    mode = 2'b11;
    go("flip_dn", 8'h02, 3'd1, 1'b1, 1'b0);
    go("flip_adv0", 8'h01, 3'd0, 1'b1, 1'b1);

    // DIV_MAX=1 instance: advances every enabled cycle with step held high.
    sys_rst = 1'b1;
    go2("d1_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    sys_rst = 1'b0; en = 1'b1; mode = 2'b10;
    exp_i = 3'd0;
    for (int k = 0; k < 9; k++) begin
      exp_i = exp_i + 3'd1;
      go2("d1_scan", 8'h01 << exp_i, exp_i, 1'b1, 1'b1);
    end
    en = 1'b0;
    go2("d1_frz", 8'h01 << exp_i, exp_i, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
